pipe_drain: RTL and testbench
=============================

# pipe_drain

Shutdown-side counterpart to the startup saturation counter. The startup counter raises its saturated flag once the machine has been out of reset long enough to run. This block does the reverse at the end of a run. On a halt request it gates instruction fetch, waits until the pipeline has been idle for DEPTH consecutive cycles, then asserts `drained`. It sits beside the fetch stage and feeds the halt/stall logic and the testbench end-of-simulation detector.

## Interface
- `DEPTH`, default 5: consecutive idle cycles required to declare the pipeline empty (number of pipeline stages); legal range 1..15.
- `TIMEOUT`, default 255: maximum cycles spent in DRAIN before `err` is raised; legal range DEPTH+1..255.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-low (0 = reset); deassertion synchronous to `clk` is the driver's responsibility.
- `halt_req`  input  1  level request to stop; sampled each cycle.
- `resume`  input  1  one-cycle pulse; returns block to RUN from DONE or ERR.
- `busy`  input  1  OR of all stage-valid bits; 1 = some stage holds a live instruction.
- `stop_fetch`  output  1  registered; 1 = fetch must not issue new instructions.
- `drained`  output  1  registered; 1 = pipeline confirmed empty.
- `err`  output  1  registered; 1 = drain timed out.
- `idle_cnt`  output  4  registered; current consecutive-idle count (debug/visibility).

## Operation
- States: RUN (00), DRAIN (01), DONE (10), ERR (11). The state register and both counters reset asynchronously.
- Reset (`rst`=0): state=RUN, `idle_cnt`=0, `tmo_cnt`=0, `stop_fetch`=0, `drained`=0, `err`=0.
- RUN:
  - `halt_req`=1 → DRAIN, clear both counters.
  - Otherwise stay in RUN; counters held at 0.
- DRAIN:
  - `stop_fetch`=1.
  - Counting: `busy`=1 → `idle_cnt`←0; `busy`=0 → `idle_cnt`←`idle_cnt`+1, saturating at DEPTH.
  - `tmo_cnt` increments every cycle (8-bit, saturating at 255).
  - If next `idle_cnt`==DEPTH → DONE.
  - Else if next `tmo_cnt`==TIMEOUT → ERR.
  - DONE has priority over ERR when both occur on the same cycle.
  - `halt_req` dropping during DRAIN is ignored; once drain starts, it completes.
- DONE: `stop_fetch`=1, `drained`=1. `idle_cnt` holds DEPTH. `busy`=1 here does not clear `drained`; it is the caller's fault and is ignored.
- ERR: `stop_fetch`=1, `err`=1, `drained`=0; counters frozen.
- `resume`:
  - In DONE or ERR: `resume`=1 → RUN, counters cleared.
  - In RUN or DRAIN: `resume` is ignored.
  - `resume` and `halt_req` both 1 in DONE → RUN this cycle. DRAIN is re-entered the following cycle if `halt_req` is still 1.
- Outputs are decoded from the registered next-state, so they change on the same edge as the state. No combinational path from inputs to outputs.

## Timing
- `halt_req` sampled high at edge k → `stop_fetch`=1 after edge k.
- Idle counting starts with `busy` sampled at edge k+1.
- Minimum drain: `busy`=0 throughout → `drained`=1 after edge k+DEPTH.
- A `busy` pulse at edge j restarts the count → `drained` no earlier than edge j+DEPTH.
- Timeout: with `busy` stuck at 1, `err`=1 after edge k+TIMEOUT.
- `resume` at edge m → `stop_fetch`, `drained`, `err` all 0 after edge m.
- `rst` asserted mid-DRAIN → all outputs 0 immediately (asynchronous), with no clock required.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles, release, hold inputs 0 for 10 cycles → all outputs 0, `idle_cnt`=0 throughout.
- Clean drain, DEPTH=5: `halt_req`=1 at edge 3, `busy`=0 → `stop_fetch`=1 from edge 3, `idle_cnt` 1..5 on edges 4–8, `drained`=1 after edge 8.
- Restart on busy: as above, but `busy`=1 at edge 6 → `idle_cnt` returns to 0 at edge 6, `drained`=1 after edge 11.
- Timeout, TIMEOUT=20: `halt_req` at edge 2, `busy` stuck 1 → `err`=1 after edge 22, `drained`=0; `resume` at edge 30 → all outputs 0 after edge 30.
- Resume/halt collision: in DONE, `resume`=1 and `halt_req`=1 at the same edge → RUN for one cycle with `stop_fetch`=0, then DRAIN and `stop_fetch`=1 on the next edge.
- Async reset mid-drain: `rst`=0 between clock edges while `idle_cnt`=3 → outputs 0 before the next edge; after release, no `drained` without a new `halt_req`.

Source files
------------

// File: rtl/pipe_drain.sv
// Shutdown drain controller: on halt request, gates fetch and waits for DEPTH
// consecutive idle cycles before declaring the pipeline drained.
//
// state | meaning
// RUN   | normal operation, fetch enabled, counters held at 0
// DRAIN | fetch gated, counting consecutive idle cycles and total drain time
// DONE  | pipeline confirmed empty, drained asserted until resume
// ERR   | drain timed out, err asserted until resume, counters frozen
module pipe_drain #(
    parameter int DEPTH   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       halt_req,
    input  logic       resume,
    input  logic       busy,
    output logic       stop_fetch,
    output logic       drained,
    output logic       err,
    output logic [3:0] idle_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10,
        ERR   = 2'b11
    } state_t;

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [7:0] TMO_C   = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [3:0] idle_nxt;
    logic [7:0] tmo_cnt, tmo_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            idle_cnt   <= '0;
            tmo_cnt    <= '0;
            stop_fetch <= 1'b0;
            drained    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            idle_cnt   <= idle_nxt;
            tmo_cnt    <= tmo_nxt;
            // outputs decoded from next state so they move on the same edge as state
            stop_fetch <= (state_nxt != RUN);
            drained    <= (state_nxt == DONE);
            err        <= (state_nxt == ERR);
        end
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        tmo_nxt   = tmo_cnt;
        case (state)
            RUN: begin
                idle_nxt = '0;
                tmo_nxt  = '0;
                if (halt_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (busy)                     idle_nxt = '0;
                else if (idle_cnt >= DEPTH_C) idle_nxt = DEPTH_C;
                else                          idle_nxt = idle_cnt + 4'd1;
                tmo_nxt = (tmo_cnt == 8'hff) ? 8'hff : tmo_cnt + 8'd1;
                // DONE wins over ERR when both land on the same cycle
                if (idle_nxt == DEPTH_C)     state_nxt = DONE;
                else if (tmo_nxt == TMO_C)   state_nxt = ERR;
            end
            DONE: begin
                idle_nxt = DEPTH_C;
                if (resume) begin
                    state_nxt = RUN;
                    idle_nxt  = '0;
                    tmo_nxt   = '0;
                end
            end
            ERR: begin
                if (resume) begin
                    state_nxt = RUN;
                    idle_nxt  = '0;
                    tmo_nxt   = '0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_pipe_drain.sv
// Directed self-checking bench for pipe_drain with DEPTH=5, TIMEOUT=20.
module tb_pipe_drain;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       halt_req = 1'b0;
    logic       resume = 1'b0;
    logic       busy = 1'b0;
    logic       stop_fetch, drained, err;
    logic [3:0] idle_cnt;

    int errors = 0;
    int checks = 0;

    pipe_drain #(.DEPTH(5), .TIMEOUT(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .halt_req   (halt_req),
        .resume     (resume),
        .busy       (busy),
        .stop_fetch (stop_fetch),
        .drained    (drained),
        .err        (err),
        .idle_cnt   (idle_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic sf, input logic dr,
                           input logic er, input logic [3:0] ic);
        chk({tag, ".stop_fetch"}, {7'd0, stop_fetch}, {7'd0, sf});
        chk({tag, ".drained"},    {7'd0, drained},    {7'd0, dr});
        chk({tag, ".err"},        {7'd0, err},        {7'd0, er});
        chk({tag, ".idle_cnt"},   {4'd0, idle_cnt},   {4'd0, ic});
    endtask

    initial begin
        // reset then idle
        #1;
        chk_all("reset", 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("idle_run", 0, 0, 0, 0);
        end

        // clean drain, halt dropping mid-drain is ignored
        halt_req = 1'b1;
        tick();
        chk_all("drain_entry", 1, 0, 0, 0);
        halt_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("clean_drain", 1, (i == 5), 0, 4'(i));
        end
        busy = 1'b1;
        tick();
        chk_all("done_busy_ignored", 1, 1, 0, 5);
        busy = 1'b0;
        resume = 1'b1;
        tick();
        chk_all("resume_from_done", 0, 0, 0, 0);
        resume = 1'b0;

        // restart on busy
        halt_req = 1'b1;
        tick();
        chk_all("restart_entry", 1, 0, 0, 0);
        halt_req = 1'b0;
        tick();
        chk_all("restart_idle1", 1, 0, 0, 1);
        tick();
        chk_all("restart_idle2", 1, 0, 0, 2);
        busy = 1'b1;
        tick();
        chk_all("restart_busy", 1, 0, 0, 0);
        busy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("restart_count", 1, (i == 5), 0, 4'(i));
        end

        // resume and halt collide in DONE
        resume   = 1'b1;
        halt_req = 1'b1;
        tick();
        chk_all("collide_run", 0, 0, 0, 0);
        resume = 1'b0;
        tick();
        chk_all("collide_redrain", 1, 0, 0, 0);
        halt_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("collide_drain", 1, (i == 5), 0, 4'(i));
        end
        resume = 1'b1;
        tick();
        chk_all("collide_resume", 0, 0, 0, 0);
        resume = 1'b0;

        // timeout with busy stuck high
        halt_req = 1'b1;
        busy     = 1'b1;
        tick();
        chk_all("tmo_entry", 1, 0, 0, 0);
        halt_req = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            chk_all("tmo_wait", 1, 0, 0, 0);
        end
        tick();
        chk_all("tmo_err", 1, 0, 1, 0);
        busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("err_frozen", 1, 0, 1, 0);
        end
        resume = 1'b1;
        tick();
        chk_all("resume_from_err", 0, 0, 0, 0);
        resume = 1'b0;

        // idle count completes on the same cycle timeout is reached: DONE wins
        halt_req = 1'b1;
        busy     = 1'b1;
        tick();
        halt_req = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        chk_all("prio_busy_phase", 1, 0, 0, 0);
        busy = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        chk_all("prio_pre", 1, 0, 0, 4);
        tick();
        chk_all("prio_done", 1, 1, 0, 5);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk_all("prio_resume", 0, 0, 0, 0);

        // asynchronous reset mid-drain
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        tick();
        tick();
        chk_all("async_pre", 1, 0, 0, 3);
        #2 rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("post_rst", 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
